ahb_lite_interconnect: RTL and testbench

- Parametrised single-master AHB-Lite interconnect: address decoder, data-phase select register, read/response multiplexer and a built-in default slave.
- Sits between the master-side AHB interface and NUM_SLAVES slave instances.
- Successor to the fixed one-master/one-slave hookup.
- Supports N slaves, configurable address map, and generates ERROR responses for unmapped accesses.

---
 rtl/ahb_ic_pkg.sv | 33 +++
 rtl/ahb_default_slave.sv | 67 ++++++
 rtl/ahb_lite_interconnect.sv | 166 ++++++++++++++++
 tb/tb_ahb_lite_interconnect.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_ic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_ic_pkg
//  Brief    : Shared types and constants for the AHB-Lite interconnect:
//             transfer-type encoding, response constants and the states of
//             the built-in default slave.
//  Revision : 1.0  initial release
// ============================================================================
package ahb_ic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } defslv_state_e;

    // A transfer only needs a data-phase response when it is NONSEQ or SEQ.
    function automatic logic htrans_active(input logic [1:0] trans);
        return (htrans_e'(trans) == NONSEQ) || (htrans_e'(trans) == SEQ);
    endfunction

endpackage : ahb_ic_pkg
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_default_slave
//  Brief    : Answers active transfers to unmapped addresses with the
//             standard two-cycle AHB ERROR response. Outputs are registered
//             so they are valid from the first cycle of the data phase.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_default_slave
    import ahb_ic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic def_load,      // data phase to the default slave starts next cycle
    output logic hreadyout,
    output logic hresp
);

    defslv_state_e state_q;
    logic          hreadyout_q;
    logic          hresp_q;

    // Error-response FSM; outputs are computed for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DS_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    if (def_load) begin
                        state_q     <= DS_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state_q     <= DS_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (def_load) begin
                        state_q     <= DS_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else begin
                        state_q     <= DS_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q     <= DS_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule : ahb_default_slave
`default_nettype wire

// File: rtl/ahb_lite_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_interconnect
//  Brief    : Single-master AHB-Lite interconnect: address decoder, data-phase
//             select register, response/read-data multiplexer and a built-in
//             default slave that errors unmapped active transfers.
//             Optional per-slave transfer and error counters are built when
//             the macro AHB_IC_PERF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_lite_interconnect
    import ahb_ic_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = {4{32'hF000_0000}}
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [AW-1:0]            HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    output logic                     HREADY,
    output logic [DW-1:0]            HRDATA,
    output logic                     HRESP,
    output logic [NUM_SLAVES-1:0]    HSEL_S,
    input  logic [NUM_SLAVES*DW-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]    HRESP_S
`ifdef AHB_IC_PERF_EN
    ,
    input  logic                     perf_clr,
    output logic [NUM_SLAVES*16-1:0] perf_xfer_cnt,
    output logic [15:0]              perf_err_cnt
`endif
);

    logic [NUM_SLAVES-1:0] w_hsel;
    logic                  w_hit;
    logic                  w_hready;
    logic                  w_hresp;
    logic [DW-1:0]         w_hrdata;
    logic                  w_def_load;
    logic                  ds_hready;
    logic                  ds_hresp;

    // Data-phase select: one-hot slave vector plus a default-slave flag;
    // all zero encodes NONE.
    logic [NUM_SLAVES-1:0] dsel_slv_d, dsel_slv_q;
    logic                  dsel_def_d, dsel_def_q;

    // Address decode; lowest matching index wins so HSEL_S stays one-hot.
    always_comb begin
        w_hsel = '0;
        w_hit  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!w_hit && ((HADDR & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                w_hsel[i] = 1'b1;
                w_hit     = 1'b1;
            end
        end
    end

    assign HSEL_S     = w_hsel;
    assign w_def_load = w_hready && !w_hit && htrans_active(HTRANS);

    // Next data-phase select: sampled only when the current data phase ends.
    always_comb begin
        dsel_slv_d = dsel_slv_q;
        dsel_def_d = dsel_def_q;
        if (w_hready) begin
            dsel_slv_d = w_hsel;
            dsel_def_d = !w_hit && htrans_active(HTRANS);
        end
    end

    // Data-phase select register; the only pipeline stage in the block.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_slv_q <= '0;
            dsel_def_q <= 1'b0;
        end else begin
            dsel_slv_q <= dsel_slv_d;
            dsel_def_q <= dsel_def_d;
        end
    end

    ahb_default_slave u_default_slave (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .def_load  (w_def_load),
        .hreadyout (ds_hready),
        .hresp     (ds_hresp)
    );

    // Response and read-data mux steered by the data-phase select.
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        w_hrdata = '0;
        if (dsel_def_q) begin
            w_hready = ds_hready;
            w_hresp  = ds_hresp;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_slv_q[i]) begin
                    w_hready = HREADYOUT_S[i];
                    w_hresp  = HRESP_S[i];
                    w_hrdata = HRDATA_S[i*DW +: DW];
                end
            end
        end
    end

    assign HREADY = w_hready;
    assign HRESP  = w_hresp;
    assign HRDATA = w_hrdata;

`ifdef AHB_IC_PERF_EN
    logic [NUM_SLAVES*16-1:0] xfer_cnt_d, xfer_cnt_q;
    logic [15:0]              err_cnt_d, err_cnt_q;

    // Saturating counters; a clear request overrides any increment.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (perf_clr) begin
            xfer_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (w_hready && dsel_slv_q[i] && (xfer_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                    xfer_cnt_d[i*16 +: 16] = xfer_cnt_q[i*16 +: 16] + 16'd1;
                end
            end
            // Ready together with ERROR from the default slave marks its ERR2 cycle.
            if (ds_hready && ds_hresp && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign perf_xfer_cnt = xfer_cnt_q;
    assign perf_err_cnt  = err_cnt_q;
`endif

    // Write direction only matters to slaves and external monitors.
    logic unused_ok;
    assign unused_ok = HWRITE;

endmodule : ahb_lite_interconnect
`default_nettype wire

// File: tb/tb_ahb_lite_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_interconnect
//  Brief    : Directed self-checking bench for ahb_lite_interconnect with the
//             default 4-slave map. Counter checks are built when
//             AHB_IC_PERF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_lite_interconnect;
    import ahb_ic_pkg::*;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              HCLK;
    logic              HRESETn;
    logic [AW-1:0]     HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic              HREADY;
    logic [DW-1:0]     HRDATA;
    logic              HRESP;
    logic [NS-1:0]     HSEL_S;
    logic [NS*DW-1:0]  HRDATA_S;
    logic [NS-1:0]     HREADYOUT_S;
    logic [NS-1:0]     HRESP_S;
`ifdef AHB_IC_PERF_EN
    logic              perf_clr;
    logic [NS*16-1:0]  perf_xfer_cnt;
    logic [15:0]       perf_err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ahb_lite_interconnect u_dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .HSEL_S      (HSEL_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S)
`ifdef AHB_IC_PERF_EN
        ,
        .perf_clr      (perf_clr),
        .perf_xfer_cnt (perf_xfer_cnt),
        .perf_err_cnt  (perf_err_cnt)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled 3 later.
    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [1:0] t);
        HADDR  = a;
        HTRANS = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn     = 1'b0;
        HWRITE      = 1'b0;
        HRDATA_S    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA0A0_0000};
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        drive(32'h8000_0000, IDLE);
`ifdef AHB_IC_PERF_EN
        perf_clr = 1'b0;
`endif
        settle();
        chk("rst_hready", 64'(HREADY), 64'd1);
        chk("rst_hresp",  64'(HRESP),  64'd0);
        chk("rst_hrdata", 64'(HRDATA), 64'd0);
        next_cycle();
        HRESETn = 1'b1;

        // Zero-wait read from slave 1.
        next_cycle();
        drive(32'h1000_0004, NONSEQ);
        settle();
        chk("s1_hsel",   64'(HSEL_S), 64'b0010);
        chk("s1_aready", 64'(HREADY), 64'd1);
        next_cycle();
        drive(32'h8000_0000, IDLE);
        settle();
        chk("s1_hrdata", 64'(HRDATA), 64'hDEAD_BEEF);
        chk("s1_hready", 64'(HREADY), 64'd1);
        chk("s1_hresp",  64'(HRESP),  64'd0);

        // Slave 2 with three wait states; new address to slave 0 during the wait.
        next_cycle();
        drive(32'h2000_0000, NONSEQ);
        HREADYOUT_S = 4'b1011;
        settle();
        chk("s2_hsel", 64'(HSEL_S), 64'b0100);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            if (k == 0) drive(32'h0000_0010, NONSEQ);
            settle();
            chk("s2_wait_hready", 64'(HREADY), 64'd0);
            chk("s2_wait_hrdata", 64'(HRDATA), 64'h2222_2222);
            chk("s2_wait_hsel",   64'(HSEL_S), 64'b0001);
        end
        next_cycle();
        HREADYOUT_S = '1;
        settle();
        chk("s2_done_hready", 64'(HREADY), 64'd1);
        chk("s2_done_hrdata", 64'(HRDATA), 64'h2222_2222);
        next_cycle();
        drive(32'h8000_0000, IDLE);
        settle();
        chk("s0_hrdata", 64'(HRDATA), 64'hA0A0_0000);

        // Two back-to-back unmapped NONSEQ transfers.
        next_cycle();
        drive(32'h8000_0000, NONSEQ);
        settle();
        chk("um_hsel",   64'(HSEL_S), 64'b0000);
        chk("um_aready", 64'(HREADY), 64'd1);
        next_cycle();
        settle();
        chk("um_err1a", 64'({HREADY, HRESP}), 64'b01);
        chk("um_err1a_data", 64'(HRDATA), 64'd0);
        next_cycle();
        settle();
        chk("um_err2a", 64'({HREADY, HRESP}), 64'b11);
        next_cycle();
        settle();
        chk("um_err1b", 64'({HREADY, HRESP}), 64'b01);
        next_cycle();
        drive(32'h8000_0000, IDLE);
        settle();
        chk("um_err2b", 64'({HREADY, HRESP}), 64'b11);

        // IDLE to an unmapped address never errors.
        next_cycle();
        settle();
        chk("idle_um_a", 64'({HREADY, HRESP}), 64'b10);
        next_cycle();
        settle();
        chk("idle_um_b", 64'({HREADY, HRESP}), 64'b10);

        // Asynchronous reset in the middle of ERR1.
        next_cycle();
        drive(32'h8000_0000, NONSEQ);
        next_cycle();
        settle();
        chk("ar_err1", 64'({HREADY, HRESP}), 64'b01);
        drive(32'h3000_0000, IDLE);
        HRESETn = 1'b0;
        #1;
        chk("ar_hready", 64'(HREADY), 64'd1);
        chk("ar_hresp",  64'(HRESP),  64'd0);
        chk("ar_hsel",   64'(HSEL_S), 64'b1000);
        next_cycle();
        HRESETn = 1'b1;
        drive(32'h3000_0004, NONSEQ);
        settle();
        chk("s3_hsel", 64'(HSEL_S), 64'b1000);
        next_cycle();
        drive(32'h8000_0000, IDLE);
        settle();
        chk("s3_hrdata", 64'(HRDATA), 64'h3333_3333);
        chk("s3_resp",   64'({HREADY, HRESP}), 64'b10);

`ifdef AHB_IC_PERF_EN
        // Five slave-0 transfers and two unmapped ones after a clear.
        next_cycle();
        perf_clr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            perf_clr = 1'b0;
            drive(AW'(k * 4), NONSEQ);
        end
        next_cycle();
        drive(32'h8000_0000, NONSEQ);
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        drive(32'h8000_0000, IDLE);
        next_cycle();
        settle();
        chk("perf_xfer0", 64'(perf_xfer_cnt[15:0]),  64'd5);
        chk("perf_xfer3", 64'(perf_xfer_cnt[63:48]), 64'd0);
        chk("perf_err",   64'(perf_err_cnt),         64'd2);
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        settle();
        chk("perf_clr_xfer0", 64'(perf_xfer_cnt[15:0]), 64'd0);
        chk("perf_clr_err",   64'(perf_err_cnt),        64'd0);
`endif

        next_cycle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ahb_lite_interconnect
`default_nettype wire
